// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard controller: per-register load countdown scoreboard, memory-miss freeze,
// and redirect hold. Define HAZARD_PERF_EN to add stall/flush performance counters.
module scoreboard_hazard_unit #(
    parameter int REG_AW      = 5,
    parameter int NREGS       = 32,
    parameter int NSTAGES     = 4,
    parameter int FLUSH_DEPTH = 3,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ihit,
    input  logic                dhit,
    input  logic                dmem_req,
    input  logic                dec_valid,
    input  logic [REG_AW-1:0]   dec_rs,
    input  logic [REG_AW-1:0]   dec_rt,
    input  logic                dec_rs_used,
    input  logic                dec_rt_used,
    input  logic [REG_AW-1:0]   dec_rd,
    input  logic                dec_wr,
    input  logic                dec_load,
    input  logic                redirect,
    output logic                pc_enable,
    output logic [NSTAGES-1:0]  stage_en,
    output logic [NSTAGES-1:0]  stage_flush,
    output logic                load_stall,
    output logic                redir_fire
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    logic                any_hit;
    logic                mem_busy;
    logic                rs_busy;
    logic                rt_busy;
    logic                load_stall_raw;
    logic                redir_fire_raw;
    logic                issue;
    logic                set_en;
    logic [NSTAGES-1:0]  en_raw;
    logic [NSTAGES-1:0]  flush_raw;
    logic                redir_pend_reg;
    logic [CNT_W-1:0]    sb_reg  [NREGS];
    logic [CNT_W-1:0]    sb_next [NREGS];

    assign any_hit  = ihit | dhit;
    assign mem_busy = dmem_req & ~dhit;

    // Register 0 is hardwired, so it can never be the source of a hazard.
    assign rs_busy = dec_rs_used && (dec_rs != '0) && (sb_reg[dec_rs] != '0);
    assign rt_busy = dec_rt_used && (dec_rt != '0) && (sb_reg[dec_rt] != '0);
    assign load_stall_raw = dec_valid & (rs_busy | rt_busy);

    assign redir_fire_raw = (redirect | redir_pend_reg) & ihit & ~mem_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_fetch_en
                assign en_raw[gi] = ihit & ~load_stall_raw & ~mem_busy;
            end else begin : g_pipe_en
                assign en_raw[gi] = any_hit & ~mem_busy;
            end

            if (gi == NSTAGES - 1) begin : g_last_flush
                assign flush_raw[gi] = 1'b0;
            end else if (gi == 1) begin : g_bubble_flush
                // ID/EX also takes a bubble while decode is held by a load-use stall.
                if (gi < FLUSH_DEPTH) begin : g_redir
                    assign flush_raw[gi] = redir_fire_raw | (load_stall_raw & en_raw[1]);
                end else begin : g_noredir
                    assign flush_raw[gi] = load_stall_raw & en_raw[1];
                end
            end else if (gi < FLUSH_DEPTH) begin : g_redir_flush
                assign flush_raw[gi] = redir_fire_raw;
            end else begin : g_no_flush
                assign flush_raw[gi] = 1'b0;
            end
        end
    endgenerate

    assign issue  = en_raw[1] & dec_valid & ~load_stall_raw & ~redir_fire_raw;
    assign set_en = issue & dec_load & dec_wr & (dec_rd != '0);

    // Counters only advance when the ID/EX latch moves; a fresh load overrides the decrement.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            sb_next[i] = sb_reg[i];
            if (en_raw[1]) begin
                if (set_en && (dec_rd == REG_AW'(i))) begin
                    sb_next[i] = CNT_W'(LOAD_LAT);
                end else if (sb_reg[i] != '0) begin
                    sb_next[i] = sb_reg[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                sb_reg[i] <= sb_next[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            redir_pend_reg <= 1'b0;
        end else begin
            redir_pend_reg <= (redir_pend_reg | redirect) & ~redir_fire_raw;
        end
    end

    // Outputs are forced low for the whole time reset is held.
    assign pc_enable   = ~RST & (en_raw[0] | redir_fire_raw);
    assign stage_en    = RST ? '0 : en_raw;
    assign stage_flush = RST ? '0 : flush_raw;
    assign load_stall  = ~RST & load_stall_raw;
    assign redir_fire  = ~RST & redir_fire_raw;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (load_stall_raw & en_raw[1]) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (redir_fire_raw) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: two instances (LOAD_LAT=1 and 3) share one stimulus table;
// expected output vectors are queued at drive time and compared at the following negedge.
module tb_scoreboard_hazard_unit;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, dmem_req, dec_valid;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic        dec_rs_used, dec_rt_used, dec_wr, dec_load, redirect;

    logic        pc_enable1, load_stall1, redir_fire1;
    logic [3:0]  stage_en1, stage_flush1;
    logic        pc_enable3, load_stall3, redir_fire3;
    logic [3:0]  stage_en3, stage_flush3;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall1, perf_flush1, perf_stall3, perf_flush3;
`endif

    int checks = 0;
    int errors = 0;

    scoreboard_hazard_unit #(.LOAD_LAT(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_rd(dec_rd),
        .dec_wr(dec_wr), .dec_load(dec_load), .redirect(redirect),
        .pc_enable(pc_enable1), .stage_en(stage_en1), .stage_flush(stage_flush1),
        .load_stall(load_stall1), .redir_fire(redir_fire1)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall1), .perf_flush_cnt(perf_flush1)
`endif
    );

    scoreboard_hazard_unit #(.LOAD_LAT(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_rd(dec_rd),
        .dec_wr(dec_wr), .dec_load(dec_load), .redirect(redirect),
        .pc_enable(pc_enable3), .stage_en(stage_en3), .stage_flush(stage_flush3),
        .load_stall(load_stall3), .redir_fire(redir_fire3)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall3), .perf_flush_cnt(perf_flush3)
`endif
    );

    // Packed view: {pc_enable, stage_en[3:0], stage_flush[3:0], load_stall, redir_fire}
    logic [10:0] o1, o3;
    assign o1 = {pc_enable1, stage_en1, stage_flush1, load_stall1, redir_fire1};
    assign o3 = {pc_enable3, stage_en3, stage_flush3, load_stall3, redir_fire3};

    localparam logic [10:0] RUN  = 11'b1_1111_0000_0_0;
    localparam logic [10:0] STL  = 11'b0_1110_0010_1_0;
    localparam logic [10:0] MISS = 11'b0_0000_0000_1_0;
    localparam logic [10:0] ZERO = 11'b0_0000_0000_0_0;
    localparam logic [10:0] FIRE = 11'b1_1111_0111_0_1;
    localparam logic [10:0] FIRS = 11'b1_1110_0111_1_1;
    localparam logic [10:0] DHO  = 11'b0_1110_0000_0_0;

    typedef struct {
        logic        ihit, dhit, dmem_req, valid;
        logic [4:0]  rs, rt;
        logic        rs_used, rt_used;
        logic [4:0]  rd;
        logic        wr, load, redir;
        logic [10:0] exp1, exp3;
    } vec_t;

    typedef struct {
        int          idx;
        logic [10:0] exp1, exp3;
    } exp_t;

    localparam int NVEC = 43;
    vec_t tbl [NVEC];
    exp_t exp_q [$];

    function automatic vec_t mk(logic ih, logic dh, logic dm, logic vl,
                                logic [4:0] rs, logic [4:0] rt, logic ru, logic tu,
                                logic [4:0] rd, logic wr, logic ld, logic rf,
                                logic [10:0] e1, logic [10:0] e3);
        vec_t v;
        v.ihit = ih; v.dhit = dh; v.dmem_req = dm; v.valid = vl;
        v.rs = rs; v.rt = rt; v.rs_used = ru; v.rt_used = tu;
        v.rd = rd; v.wr = wr; v.load = ld; v.redir = rf;
        v.exp1 = e1; v.exp3 = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; dmem_req = v.dmem_req; dec_valid = v.valid;
        dec_rs = v.rs; dec_rt = v.rt; dec_rs_used = v.rs_used; dec_rt_used = v.rt_used;
        dec_rd = v.rd; dec_wr = v.wr; dec_load = v.load; redirect = v.redir;
    endtask

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        exp_t e;
        vec_t idle;
        vec_t cons;

        idle = mk(1,0,0,0, 0,0,0,0, 0,0,0,0, RUN, RUN);
        cons = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN, RUN);

        tbl[0]  = idle;
        tbl[1]  = mk(1,0,0,1, 1,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8
        tbl[2]  = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, STL,  STL);   // add uses r8
        tbl[3]  = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[4]  = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[5]  = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  RUN);
        tbl[6]  = mk(1,0,0,1, 9,0,1,1, 11,1,0,0, RUN,  RUN);   // r9 never loaded
        tbl[7]  = mk(1,0,0,1, 9,0,1,0,  0,1,1,0, RUN,  RUN);   // load to r0 is ignored
        tbl[8]  = mk(1,0,0,1, 0,0,1,1, 12,1,0,0, RUN,  RUN);   // consumer of r0
        tbl[9]  = mk(1,0,0,1, 0,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8
        for (int i = 10; i < 15; i++) begin
            tbl[i] = mk(1,0,1,1, 8,0,1,0, 10,1,0,0, MISS, MISS); // data miss freezes all
        end
        tbl[15] = mk(1,1,1,1, 8,0,1,0, 10,1,0,0, STL,  STL);   // dhit returns
        tbl[16] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[17] = mk(1,0,0,1, 8,8,0,1, 10,1,0,0, RUN,  STL);   // rt path
        tbl[18] = mk(1,0,0,1, 8,8,0,1, 10,1,0,0, RUN,  RUN);
        tbl[19] = mk(1,0,0,1, 0,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8
        tbl[20] = mk(1,0,0,1, 8,3,0,1, 10,1,0,0, RUN,  RUN);   // rs not read
        tbl[21] = mk(1,0,0,0, 8,8,1,1,  0,0,0,0, RUN,  RUN);   // not valid
        tbl[22] = mk(1,0,0,0, 8,8,1,1,  0,0,0,0, RUN,  RUN);
        tbl[23] = mk(0,0,0,0, 0,0,0,0,  0,0,0,1, ZERO, ZERO);  // redirect without ihit
        tbl[24] = mk(0,0,0,0, 0,0,0,0,  0,0,0,1, ZERO, ZERO);
        tbl[25] = mk(1,0,0,0, 0,0,0,0,  0,0,0,0, FIRE, FIRE);  // pending redirect fires
        tbl[26] = idle;
        tbl[27] = mk(1,0,1,0, 0,0,0,0,  0,0,0,1, ZERO, ZERO);  // redirect under miss
        tbl[28] = mk(1,0,0,0, 0,0,0,0,  0,0,0,0, FIRE, FIRE);
        tbl[29] = idle;
        tbl[30] = mk(1,0,0,1, 0,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8
        tbl[31] = mk(1,0,0,1, 8,0,1,0, 10,1,0,1, FIRS, FIRS);  // stall + redirect
        tbl[32] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[33] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[34] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  RUN);
        tbl[35] = mk(1,0,0,1, 0,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8
        tbl[36] = mk(1,0,0,1, 0,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8 again: set beats decrement
        tbl[37] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, STL,  STL);
        tbl[38] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[39] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  STL);
        tbl[40] = mk(1,0,0,1, 8,0,1,0, 10,1,0,0, RUN,  RUN);
        tbl[41] = mk(1,0,0,1, 0,0,1,0,  8,1,1,0, RUN,  RUN);   // lw r8
        tbl[42] = mk(0,1,0,0, 0,0,0,0,  0,0,0,1, DHO,  DHO);   // dhit only: r8 counts down, redirect pends

        // Reset held with busy inputs: every output must be low.
        RST = 1'b1;
        drive(mk(1,0,0,1, 8,8,1,1, 8,1,1,1, ZERO, ZERO));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_dut1", 32'(o1), 32'(ZERO));
        check("reset_dut3", 32'(o3), 32'(ZERO));
        #1;
        drive(idle);
        RST = 1'b0;
        @(posedge CLK);

        for (int i = 0; i < NVEC; i++) begin
            #1;
            drive(tbl[i]);
            e.idx = i; e.exp1 = tbl[i].exp1; e.exp3 = tbl[i].exp3;
            exp_q.push_back(e);
            @(negedge CLK);
            e = exp_q.pop_front();
            $display("row %0d dut1=%b dut3=%b", e.idx, o1, o3);
            check($sformatf("row%0d_dut1", e.idx), 32'(o1), 32'(e.exp1));
            check($sformatf("row%0d_dut3", e.idx), 32'(o3), 32'(e.exp3));
            @(posedge CLK);
        end

`ifdef HAZARD_PERF_EN
        #1;
        check("perf_stall_dut1", perf_stall1, 32'd4);
        check("perf_flush_dut1", perf_flush1, 32'd3);
        check("perf_stall_dut3", perf_stall3, 32'd12);
        check("perf_flush_dut3", perf_flush3, 32'd3);
`endif

        // Async reset mid-cycle while dut3 holds r8=2 and a redirect is pending.
        #1;
        drive(cons);
        #2;
        RST = 1'b1;
        #1;
        $display("async reset dut1=%b dut3=%b", o1, o3);
        check("async_rst_dut1", 32'(o1), 32'(ZERO));
        check("async_rst_dut3", 32'(o3), 32'(ZERO));
        @(posedge CLK);
        #3;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        drive(cons);
        e.idx = NVEC; e.exp1 = RUN; e.exp3 = RUN;
        exp_q.push_back(e);
        @(negedge CLK);
        e = exp_q.pop_front();
        $display("post reset dut1=%b dut3=%b", o1, o3);
        check("post_rst_dut1", 32'(o1), 32'(e.exp1));
        check("post_rst_dut3", 32'(o3), 32'(e.exp3));
`ifdef HAZARD_PERF_EN
        check("post_rst_perf_stall", perf_stall3, 32'd0);
        check("post_rst_perf_flush", perf_flush3, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
